multu_unit: RTL and testbench

Iterative unsigned 32×32 multiplier with architectural HI/LO registers for the MIPS datapath. It sits directly downstream of the instruction decoder.
- Multiply starts when the decoder issues R-type funct 011001 (ALU code 011).
- HI/LO reads come from mfhi/mflo (ALU codes 100/101), selected by the datapath.
- The pipeline is stalled while a multiply is in flight and a dependent HI/LO access arrives.

---
 rtl/multu_unit.sv | 129 ++++++++++++
 tb/tb_multu_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multu_unit.sv
// multu_unit: iterative unsigned 32x32 shift-add multiplier with architectural HI/LO.
// One partial-product add per cycle, 32 cycles per product, HI/LO committed atomically.
module multu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        mf_req,
  input  logic        mt_hi,
  input  logic        mt_lo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int unsigned DW      = 32;
  localparam int unsigned PW      = 2 * DW;
  localparam int unsigned CW      = 6;
  localparam logic [CW-1:0] LAST  = CW'(DW - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q,  state_d;
  logic [PW-1:0] mcand_q,  mcand_d;
  logic [DW-1:0] mplier_q, mplier_d;
  logic [PW-1:0] acc_q,    acc_d;
  logic [CW-1:0] count_q,  count_d;
  logic [DW-1:0] hi_q,     hi_d;
  logic [DW-1:0] lo_q,     lo_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [PW-1:0] acc_step;

  // Accumulator after this cycle's conditional add of the shifted multiplicand
  always_comb begin
    acc_step = acc_q;
    if (mplier_q[0]) begin
      acc_step = acc_q + mcand_q;
    end
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // mt writes land even alongside an accepted start; the product overwrites them later
        if (mt_hi) begin
          hi_d = wdata;
        end
        if (mt_lo) begin
          lo_d = wdata;
        end
        if (start) begin
          state_d  = RUN;
          mcand_d  = {{DW{1'b0}}, srca};
          mplier_d = srcb;
          acc_d    = '0;
          count_d  = '0;
        end
      end
      RUN: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = CW'(count_q + CW'(1));
        if (count_q == LAST) begin
          state_d = IDLE;
          hi_d    = acc_step[PW-1:DW];
          lo_d    = acc_step[DW-1:0];
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers; reset aborts any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;
  // Hold the pipeline when any HI/LO-touching instruction meets a multiply in flight
  assign stall = busy_q & (start | mf_req | mt_hi | mt_lo);

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: directed stimulus, product expectations go through a scoreboard queue.
module tb_multu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        mf_req;
  logic        mt_hi;
  logic        mt_lo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  multu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .srca   (srca),
    .srcb   (srcb),
    .mf_req (mf_req),
    .mt_hi  (mt_hi),
    .mt_lo  (mt_lo),
    .wdata  (wdata),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .done   (done),
    .stall  (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding product
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no product pending at %0t", $time);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("product_hi", 64'(hi), 64'(e[63:32]));
        chk("product_lo", 64'(lo), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count busy/stall cycles until the done cycle (sampled at its negedge)
  task automatic wait_done(input string name, output int bcnt, output int scnt);
    bit seen;
    seen = 1'b0;
    bcnt = 0;
    scnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({name, "_stall_at_done"}, 64'(stall), 64'd0);
        break;
      end
      if (busy)  bcnt++;
      if (stall) scnt++;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    srca  = a;
    srcb  = b;
    exp_q.push_back(64'(a) * 64'(b));
  endtask

  initial begin
    int bc;
    int sc;
    int dones;
    reset = 1'b1; start = 1'b0; srca = '0; srcb = '0;
    mf_req = 1'b0; mt_hi = 1'b0; mt_lo = 1'b0; wdata = '0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // all-ones operands: 0xFFFFFFFE_00000001
    tick();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("ones_expect", exp_q[0], 64'hFFFF_FFFE_0000_0001);
    tick();
    start = 1'b0;
    wait_done("ones", bc, sc);
    chk("ones_busy_cycles", 64'(bc), 64'd32);
    @(negedge clk);
    chk("ones_done_pulse", 64'(done), 64'd0);

    // mf_req held across the whole multiply stalls for exactly the busy window
    tick();
    issue(32'h1234_5678, 32'h0000_0010);
    tick();
    start  = 1'b0;
    mf_req = 1'b1;
    wait_done("mf", bc, sc);
    chk("mf_busy_cycles", 64'(bc), 64'd32);
    chk("mf_stall_cycles", 64'(sc), 64'd32);
    chk("mf_hi", 64'(hi), 64'h1);
    chk("mf_lo", 64'(lo), 64'h2345_6780);
    tick();
    mf_req = 1'b0;

    // mt_hi in IDLE writes HI
    mt_hi = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("mthi_stall", 64'(stall), 64'd0);
    tick();
    mt_hi = 1'b0;
    @(negedge clk);
    chk("mthi_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mthi_lo_kept", 64'(lo), 64'h2345_6780);

    // start with mt_lo in the same cycle: write lands, then product overwrites
    tick();
    issue(32'd2, 32'd3);
    mt_lo = 1'b1;
    wdata = 32'h1111_1111;
    tick();
    start = 1'b0;
    wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("start_mt_lo", 64'(lo), 64'h1111_1111);
    chk("mtlo_busy_stall", 64'(stall), 64'd1);
    tick();
    mt_lo = 1'b0;
    @(negedge clk);
    chk("mtlo_busy_ignored", 64'(lo), 64'h1111_1111);
    chk("mtlo_hi_kept", 64'(hi), 64'hA5A5_A5A5);
    wait_done("mtlo", bc, sc);

    // second start while busy is refused; start in done cycle is accepted
    tick();
    issue(32'd3, 32'd5);
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    srca  = 32'd9;
    srcb  = 32'd9;
    @(negedge clk);
    chk("busy_start_stall", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    wait_done("b2b_first", bc, sc);
    chk("b2b_first_lo", 64'(lo), 64'd15);
    issue(32'h0001_0000, 32'h0001_0000);
    tick();
    start = 1'b0;
    wait_done("b2b_second", bc, sc);
    chk("b2b_second_busy", 64'(bc), 64'd32);
    chk("b2b_second_hi", 64'(hi), 64'h1);

    // reset mid-run aborts the product
    tick();
    start = 1'b1;
    srca  = 32'hFFFF;
    srcb  = 32'hFFFF;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hi", 64'(hi), 64'd0);
    chk("abort_lo", 64'(lo), 64'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", 64'(dones), 64'd0);

    // fresh multiply after abort
    tick();
    issue(32'd7, 32'd6);
    tick();
    start = 1'b0;
    wait_done("after_abort", bc, sc);
    chk("after_abort_busy", 64'(bc), 64'd32);
    chk("after_abort_lo", 64'(lo), 64'd42);

    repeat (3) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
